// File: rtl/y86_defs.sv
// rtl/y86_defs.sv - shared Y86-64 instruction, function, condition and status codes
//
// Purpose: single home for the encodings used by the execute-stage logic.
// Ports: none (package).
package y86_defs;

  // instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU function codes for OPq
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  // condition function codes for jXX / cmovXX
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // pipeline status codes
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  // condition-code register layout, {ZF,SF,OF}
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // an instruction in this state must not let younger OPqs update CC
  function automatic logic is_exception(input logic [2:0] stat);
    return (stat == S_ADR) || (stat == S_INS) || (stat == S_HLT);
  endfunction

endpackage

// File: rtl/e_cc_unit_cond_eval.sv
// rtl/e_cc_unit_cond_eval.sv - jXX/cmovXX condition evaluator
//
// Purpose: map a condition ifun and a {ZF,SF,OF} triple to a taken/move flag.
// Ports:
//   cc   in  3 : condition codes {ZF,SF,OF}
//   ifun in  4 : condition function code
//   cnd  out 1 : condition outcome (0 for undefined ifun codes)
module cond_eval
  import y86_defs::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic zf;
  logic sf;
  logic of;

  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (sf ^ of) | zf;
      C_L:     cnd = sf ^ of;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~(sf ^ of);
      C_G:     cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/e_cc_unit.sv
// rtl/e_cc_unit.sv - execute-stage condition-code unit
//
// Purpose: derive ZF/SF/OF from the ALU operands/result, hold them in the
// architectural CC register, and evaluate jXX/cmovXX conditions against the
// held CC.
// Ports:
//   clk       in  1 : core clock
//   rst_n     in  1 : synchronous active-low reset
//   E_icode   in  4 : instruction code in E
//   E_ifun    in  4 : function code in E
//   e_aluA    in  W : ALU operand A
//   e_aluB    in  W : ALU operand B
//   e_valE    in  W : ALU result
//   m_stat    in  3 : status of instruction in M
//   W_stat    in  3 : status of instruction in W
//   cc_o      out 3 : held CC {ZF,SF,OF}
//   set_cc_o  out 1 : CC write enable this cycle
//   e_cnd     out 1 : condition outcome under held CC
module e_cc_unit
  import y86_defs::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] e_aluA,
  input  logic [W-1:0] e_aluB,
  input  logic [W-1:0] e_valE,
  input  logic [2:0]   m_stat,
  input  logic [2:0]   W_stat,
  output logic [2:0]   cc_o,
  output logic         set_cc_o,
  output logic         e_cnd
);

  cc_t  cc_q;
  cc_t  cc_new;
  logic set_cc;
  logic cnd_raw;
  logic a_msb;
  logic b_msb;
  logic r_msb;

  assign a_msb = e_aluA[W-1];
  assign b_msb = e_aluB[W-1];
  assign r_msb = e_valE[W-1];

  // Only the sign bits of the operands feed overflow detection.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{e_aluA[W-2:0], e_aluB[W-2:0]};

  // OPq with an undefined ALU function is already an INS in decode; keep it
  // from touching CC. An exception in M or W blocks every younger OPq.
  assign set_cc = (E_icode == I_OPQ) && (E_ifun <= ALU_XOR)
                  && !is_exception(m_stat) && !is_exception(W_stat);

  always_comb begin
    cc_new    = '0;
    cc_new.zf = (e_valE == '0);
    cc_new.sf = r_msb;
    case (E_ifun)
      ALU_ADD: cc_new.of = (a_msb == b_msb) && (r_msb != b_msb);
      ALU_SUB: cc_new.of = (a_msb != b_msb) && (r_msb != b_msb);
      default: cc_new.of = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_q <= CC_RESET;
    end else if (set_cc) begin
      cc_q <= cc_new;
    end
  end

  // The condition is evaluated on the held CC: an OPq and a dependent
  // jXX/cmov are never in E together, so no bypass of cc_new is needed.
  cond_eval u_cond_eval (
    .cc   (cc_q),
    .ifun (E_ifun),
    .cnd  (cnd_raw)
  );

  assign e_cnd    = ((E_icode == I_JXX) || (E_icode == I_CMOVXX)) ? cnd_raw : 1'b0;
  assign cc_o     = cc_q;
  assign set_cc_o = set_cc;

endmodule

// File: tb/tb_e_cc_unit.sv
// tb/tb_e_cc_unit.sv - directed vector bench for e_cc_unit
module tb_e_cc_unit;
  import y86_defs::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   E_icode;
  logic [3:0]   E_ifun;
  logic [W-1:0] e_aluA;
  logic [W-1:0] e_aluB;
  logic [W-1:0] e_valE;
  logic [2:0]   m_stat;
  logic [2:0]   W_stat;
  logic [2:0]   cc_o;
  logic         set_cc_o;
  logic         e_cnd;

  always #5 clk = ~clk;

  e_cc_unit #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .E_icode  (E_icode),
    .E_ifun   (E_ifun),
    .e_aluA   (e_aluA),
    .e_aluB   (e_aluB),
    .e_valE   (e_valE),
    .m_stat   (m_stat),
    .W_stat   (W_stat),
    .cc_o     (cc_o),
    .set_cc_o (set_cc_o),
    .e_cnd    (e_cnd)
  );

  typedef struct {
    string        name;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [63:0]  vale;
    logic [2:0]   ms;
    logic [2:0]   ws;
    logic         exp_set;
    logic         exp_cnd;
    logic [2:0]   exp_cc;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] v,
                       input logic [2:0] ms, input logic [2:0] ws);
    E_icode = ic; E_ifun = fn; e_aluA = a; e_aluB = b; e_valE = v;
    m_stat = ms; W_stat = ws;
  endtask

  initial begin
    // {name, icode, ifun, aluA, aluB, valE, m_stat, W_stat, set_cc, cnd, cc after edge}
    vecs.push_back('{"addq_ovf",   I_OPQ,    ALU_ADD, MAXP, MAXP, 64'hFFFF_FFFF_FFFF_FFFE, S_AOK, S_AOK, 1'b1, 1'b0, 3'b011});
    vecs.push_back('{"jl_after_add",  I_JXX, C_L,  0, 0, 0, S_AOK, S_AOK, 1'b0, 1'b0, 3'b011});
    vecs.push_back('{"jle_after_add", I_JXX, C_LE, 0, 0, 0, S_AOK, S_AOK, 1'b0, 1'b0, 3'b011});
    vecs.push_back('{"subq_zero",  I_OPQ,    ALU_SUB, 64'd5, 64'd5, 64'd0, S_AOK, S_AOK, 1'b1, 1'b0, 3'b100});
    vecs.push_back('{"cmovne_z",   I_CMOVXX, C_NE, 0, 0, 0, S_AOK, S_AOK, 1'b0, 1'b0, 3'b100});
    vecs.push_back('{"cmove_z",    I_CMOVXX, C_E,  0, 0, 0, S_AOK, S_AOK, 1'b0, 1'b1, 3'b100});
    vecs.push_back('{"subq_novf",  I_OPQ,    ALU_SUB, 64'd1, MINN, MAXP, S_AOK, S_AOK, 1'b1, 1'b0, 3'b001});
    vecs.push_back('{"jl_of",      I_JXX,    C_L,  0, 0, 0, S_AOK, S_AOK, 1'b0, 1'b1, 3'b001});
    vecs.push_back('{"jg_of",      I_JXX,    C_G,  0, 0, 0, S_AOK, S_AOK, 1'b0, 1'b0, 3'b001});
    vecs.push_back('{"jge_of",     I_JXX,    C_GE, 0, 0, 0, S_AOK, S_AOK, 1'b0, 1'b0, 3'b001});
    vecs.push_back('{"andq_neg",   I_OPQ,    ALU_AND, MINN, ALL1, MINN, S_AOK, S_AOK, 1'b1, 1'b0, 3'b010});
    vecs.push_back('{"xorq_m_adr", I_OPQ,    ALU_XOR, 64'd5, 64'd5, 64'd0, S_ADR, S_AOK, 1'b0, 1'b0, 3'b010});
    vecs.push_back('{"xorq_w_hlt", I_OPQ,    ALU_XOR, 64'd5, 64'd5, 64'd0, S_AOK, S_HLT, 1'b0, 1'b0, 3'b010});
    vecs.push_back('{"xorq_m_ins", I_OPQ,    ALU_XOR, 64'd5, 64'd5, 64'd0, S_INS, S_AOK, 1'b0, 1'b0, 3'b010});
    vecs.push_back('{"opq_ifun4",  I_OPQ,    4'h4,    64'd5, 64'd5, 64'd0, S_AOK, S_AOK, 1'b0, 1'b0, 3'b010});
    vecs.push_back('{"mrmovq",     I_MRMOVQ, 4'h0, 64'd8, 64'd0, 64'd8, S_AOK, S_AOK, 1'b0, 1'b0, 3'b010});
    vecs.push_back('{"jl_neg",     I_JXX,    C_L,  0, 0, 0, S_AOK, S_AOK, 1'b0, 1'b1, 3'b010});
    vecs.push_back('{"nop",        I_NOP,    4'h0, 0, 0, 0, S_AOK, S_AOK, 1'b0, 1'b0, 3'b010});
    vecs.push_back('{"jmp",        I_JXX,    C_YES,0, 0, 0, S_AOK, S_AOK, 1'b0, 1'b1, 3'b010});
    vecs.push_back('{"jxx_ifun7",  I_JXX,    4'h7, 0, 0, 0, S_AOK, S_AOK, 1'b0, 1'b0, 3'b010});
    vecs.push_back('{"cmovg_neg",  I_CMOVXX, C_G,  0, 0, 0, S_AOK, S_AOK, 1'b0, 1'b0, 3'b010});
    vecs.push_back('{"nop_cnd_yes",I_NOP,    C_YES,0, 0, 0, S_AOK, S_AOK, 1'b0, 1'b0, 3'b010});

    // reset with a flag-setting addq in E for two cycles
    rst_n = 1'b0;
    drive(I_OPQ, ALU_ADD, MAXP, MAXP, 64'hFFFF_FFFF_FFFF_FFFE, S_AOK, S_AOK);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cc", 64'(cc_o), 64'(3'b100));
    drive(I_NOP, 4'h0, 0, 0, 0, S_AOK, S_AOK);
    #1;
    chk("reset_bubble_set", 64'(set_cc_o), 64'd0);
    chk("reset_bubble_cnd", 64'(e_cnd), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(I_JXX, C_E, 0, 0, 0, S_AOK, S_AOK);
    #1;
    chk("reset_je", 64'(e_cnd), 64'd1);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].icode, vecs[i].ifun, vecs[i].a, vecs[i].b, vecs[i].vale,
            vecs[i].ms, vecs[i].ws);
      #1;
      chk({vecs[i].name, "_set"}, 64'(set_cc_o), 64'(vecs[i].exp_set));
      chk({vecs[i].name, "_cnd"}, 64'(e_cnd), 64'(vecs[i].exp_cnd));
      @(posedge clk); #1;
      chk({vecs[i].name, "_cc"}, 64'(cc_o), 64'(vecs[i].exp_cc));
    end

    // reset in the same cycle as a valid set_cc: reset wins
    rst_n = 1'b0;
    drive(I_OPQ, ALU_SUB, 64'd1, MINN, MAXP, S_AOK, S_AOK);
    #1;
    chk("rst_vs_set_en", 64'(set_cc_o), 64'd1);
    @(posedge clk); #1;
    chk("rst_vs_set_cc", 64'(cc_o), 64'(3'b100));
    rst_n = 1'b1;
    drive(I_JXX, C_LE, 0, 0, 0, S_AOK, S_AOK);
    #1;
    chk("rst_vs_set_jle", 64'(e_cnd), 64'd1);
    @(posedge clk); #1;

    // persistent W exception blocks consecutive OPqs
    drive(I_OPQ, ALU_ADD, MAXP, MAXP, 64'hFFFF_FFFF_FFFF_FFFE, S_AOK, S_ADR);
    @(posedge clk); #1;
    drive(I_OPQ, ALU_SUB, 64'd1, MINN, MAXP, S_AOK, S_ADR);
    @(posedge clk); #1;
    chk("w_exc_block_cc", 64'(cc_o), 64'(3'b100));
    // exception cleared: next OPq loads again, visible one cycle later
    drive(I_OPQ, ALU_SUB, 64'd1, MINN, MAXP, S_AOK, S_AOK);
    #1;
    chk("pre_load_cc", 64'(cc_o), 64'(3'b100));
    @(posedge clk); #1;
    chk("post_load_cc", 64'(cc_o), 64'(3'b001));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/e_cc_unit.md
# e_cc_unit

Execute-stage condition-code unit for the pipelined Y86-64 core. Consumes the 64-bit ALU operands and the result of the ADDSUB/logic datapath, derives ZF/SF/OF, and holds them in the architectural CC register. Produces `e_cnd` for jXX/cmovXX in the same execute cycle from the currently held CC. Sits directly downstream of the ALU in E. Feeds `e_cnd` to the E/M pipeline register and the branch-mispredict logic.

## Interface
- `W`, 64: datapath width.
- `clk` in 1: single core clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `E_icode` in 4: instruction code in E.
- `E_ifun` in 4: function code in E.
- `e_aluA` in W: ALU operand A (valA/valC/constant, as selected upstream).
- `e_aluB` in W: ALU operand B.
- `e_valE` in W: ALU result (`aluB+aluA`, `aluB-aluA`, `aluB&aluA`, or `aluB^aluA`).
- `m_stat` in 3: status of the instruction in M.
- `W_stat` in 3: status of the instruction in W.
- `cc_o` out 3: held CC, `{ZF,SF,OF}`.
- `set_cc_o` out 1: CC write enable for this cycle (debug/trace).
- `e_cnd` out 1: condition outcome for `E_icode`/`E_ifun` under the held `cc_o`.

## Operation
- `set_cc = (E_icode==OPQ) && !(m_stat in {ADR,INS,HLT}) && !(W_stat in {ADR,INS,HLT})`.
- Status encodings: AOK=1, HLT=2, ADR=3, INS=4. OPQ=6, JXX=7, CMOVXX=2.
- ZF = (`e_valE`==0).
- SF = `e_valE[W-1]`.
- OF for addq (ifun 0): `aluA[W-1]==aluB[W-1] && e_valE[W-1]!=aluB[W-1]`.
- OF for subq (ifun 1): `aluA[W-1]!=aluB[W-1] && e_valE[W-1]!=aluB[W-1]`.
- OF for andq/xorq (ifun 2/3): 0.
- OPq with ifun greater than 3: no CC update. Treated as `set_cc=0`; decode already flags these as INS.
- CC register: on a clock edge with `rst_n=0`, `cc_o`←3'b100 (ZF=1,SF=0,OF=0). Otherwise, if `set_cc`, `cc_o`←`{ZF,SF,OF}`; else hold.
- `e_cnd` uses the held `cc_o`, never the flags being computed this cycle. This is correct because an OPq and a dependent jXX/cmov are never in E together.
- `e_cnd` by ifun:
  - 0 always → 1
  - 1 le → `(SF^OF)|ZF`
  - 2 l → `SF^OF`
  - 3 e → `ZF`
  - 4 ne → `!ZF`
  - 5 ge → `!(SF^OF)`
  - 6 g → `!(SF^OF)&!ZF`
  - 7–15 → 0
- `e_cnd` is forced to 0 when `E_icode` is not JXX or CMOVXX. A bubble in E (icode NOP=1) therefore yields `e_cnd=0`.
- `set_cc_o` is combinational, equal to the internal `set_cc`.

## Timing
- Flag computation and `e_cnd` are combinational within the E cycle.
- The CC update becomes visible on `cc_o` one cycle after the OPq is in E.
- Reset values: `cc_o`=3'b100. `set_cc_o` and `e_cnd` follow their inputs combinationally and reach 0 during reset once E holds a bubble.
- Reset asserted in the same cycle as a valid `set_cc`: reset wins, and `cc_o`=3'b100 next cycle.
- Exception in M or W in the same cycle as an OPq in E: CC held. The exception persists in W, so all younger OPqs are also blocked until the pipeline is flushed.
- The CC register does not stall. The pipeline-control "E bubble" inserts NOP, which naturally yields `set_cc=0`.

## Structure
- Shared package/header `y86_defs` holds the icode constants (NOP, CMOVXX, OPQ, JXX, …), the ALU ifun codes, the condition ifun codes, and the stat codes (AOK, HLT, ADR, INS). No literals for these codes inside this block.
- One combinational sub-module, `cond_eval` (inputs `cc[2:0]`, `ifun[3:0]`; output `cnd`). It is reused by any later branch-resolution logic.
- Flag derivation and the CC register stay in `e_cc_unit`.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles with OPq addq in E → `cc_o`=3'b100. A jXX je (ifun 3) in E gives `e_cnd=1`.
- addq overflow: aluA=aluB=64'h7FFF_FFFF_FFFF_FFFF, valE=64'hFFFF_FFFF_FFFF_FFFE, stats AOK → next cycle `cc_o`=3'b011. A following jl (ifun 2) gives `e_cnd=0` and jle gives `e_cnd=0`.
- subq zero: aluA=aluB=64'd5, valE=0 → `cc_o`=3'b100. A following cmovne gives `e_cnd=0` and cmove gives `e_cnd=1`.
- subq negative overflow: aluB=64'h8000_0000_0000_0000, aluA=1, valE=64'h7FFF_FFFF_FFFF_FFFF → `cc_o`=3'b001. jl, jg, and jge give `e_cnd`=1, 0, and 0 respectively.
- Exception inhibit: `cc_o`=3'b010 held, then xorq producing 0 while `m_stat`=ADR → `set_cc_o=0`, and `cc_o` stays 3'b010. Repeat with `W_stat`=HLT → same.
- Non-flag instructions: after a CC load, mrmovq/jXX/NOP in E for 3 cycles → `cc_o` unchanged. NOP in E gives `e_cnd=0`. jmp (ifun 0) gives `e_cnd=1` regardless of CC.
